bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Registered round-robin arbiter for the four-master shared system bus. It drives the active-low grants m0_grnt_..m3_grnt_ that the bus mux uses to select the master.
- Grant is ownership-based: a master keeps the bus while it holds its request.
- An optional hold-time limit lets a waiting master pre-empt the owner, but only between transfers (address strobe idle).

Parameters:
HOLD_MAX, 16, cycles an owner may hold the bus before another requester may pre-empt it; 0 disables pre-emption
CNT_W, 8, width of the hold counter; must satisfy HOLD_MAX < 2**CNT_W

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
m0_req_  input  1  master 0 bus request, active low
m1_req_  input  1  master 1 bus request, active low
m2_req_  input  1  master 2 bus request, active low
m3_req_  input  1  master 3 bus request, active low
s_as_  input  1  address strobe of the currently selected master, active low; low = transfer in progress
m0_grnt_  output  1  master 0 grant, active low, registered
m1_grnt_  output  1  master 1 grant, active low, registered
m2_grnt_  output  1  master 2 grant, active low, registered
m3_grnt_  output  1  master 3 grant, active low, registered
owner  output  2  index of the current owner; valid only when busy=1
busy  output  1  1 while some grant is asserted
preempt  output  1  one-cycle pulse on the edge where a grant is revoked by timeout

Behaviour:
- Reset values (asynchronous): all m*_grnt_ = 1; owner = 0; busy = 0; preempt = 0; last = 3, so the first priority order after reset is 0,1,2,3; hold counter = 0.
- At most one grant_ is low at any time (one-hot-or-zero invariant).
- Outputs are registered. Nothing passes combinationally from req_ to grnt_.
- Round-robin order is evaluated from (last+1) mod 4 upward with wrap-around. last is updated to the new owner on every grant.
- State IDLE (busy=0):
  - If any req_ is low, grant the first requester in round-robin order at the next edge, then go to OWNED.
  - Latency is 1 cycle from req_ sampled low to grnt_ low.
- State OWNED (busy=1):
  - Owner keeps its grant while its req_ is low.
  - Owner release, with another requester pending: at the edge that samples the owner's req_ high, the grant transfers directly to the next requester in round-robin order. There is no idle cycle between owners.
  - Owner release, with no requester pending: all grants go high and the state returns to IDLE.
- Hold counter:
  - Cleared on every grant change.
  - Increments each cycle in OWNED and saturates at HOLD_MAX.
- Pre-emption, when HOLD_MAX != 0:
  - Fires when counter == HOLD_MAX, some other master's req_ is low, and s_as_ is sampled high.
  - At that edge the grant moves to the next requester in round-robin order excluding the current owner, and preempt pulses high for 1 cycle.
  - The revoked master keeps requesting and competes in normal round-robin order.
  - While s_as_ is low, pre-emption is deferred. The counter stays saturated.
- Simultaneous owner release and timeout: treat as a normal release. preempt stays 0.
- A req_ that deasserts before being granted is simply dropped; there is no request latching.
- Reset asserted mid-transfer: grants drop immediately (asynchronously) and all state returns to reset values.

Test Plan:
- Reset, then m2_req_ low at cycle 0 -> m2_grnt_ low at cycle 1, owner=2, busy=1; all other grants high.
- All four req_ low from reset, each releasing after 3 cycles of grant -> grant order 0,1,2,3,0. Each handover is zero-gap, with exactly one grant low per cycle.
- m1 owns the bus; m1_req_ high while no other request pending -> all grnt_ high next edge, busy=0, owner irrelevant.
- HOLD_MAX=4: m0 holds, m3 requests, s_as_ high -> m0 revoked and m3_grnt_ low on the 5th owned cycle's edge, preempt=1 for exactly 1 cycle.
- Same as previous, but s_as_ held low for 10 cycles -> no pre-emption until the first edge sampling s_as_ high, then handover with preempt pulse.
- Reset asserted asynchronously mid-ownership of m2 -> all grnt_ high before the next clk edge. After release, m0 wins when m0 and m3 request simultaneously.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration signals: active-low requests and grants plus arbiter status.
// The requesting side uses "master"; the arbiter itself uses "slave".
`timescale 1ns/1ps
interface bus_arbiter_if;
   logic       m0_req_;
   logic       m1_req_;
   logic       m2_req_;
   logic       m3_req_;
   logic       s_as_;
   logic       m0_grnt_;
   logic       m1_grnt_;
   logic       m2_grnt_;
   logic       m3_grnt_;
   logic [1:0] owner;
   logic       busy;
   logic       preempt;

   modport master (
      output m0_req_, m1_req_, m2_req_, m3_req_, s_as_,
      input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, busy, preempt
   );

   modport slave (
      input  m0_req_, m1_req_, m2_req_, m3_req_, s_as_,
      output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, busy, preempt
   );
endinterface

// File: rtl/bus_arbiter.sv
// Registered four-master round-robin bus arbiter with ownership-based grants and
// optional hold-time pre-emption that only fires between transfers.
`timescale 1ns/1ps
module bus_arbiter #(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 8
) (
   input  logic         clk,
   input  logic         reset,
   bus_arbiter_if.slave bus
);
   typedef enum logic {IDLE, OWNED} state_t;

   localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_MAX);
   localparam bit               PREEMPT_EN = (HOLD_MAX != 0);

   state_t           state_reg, state_next;
   logic [3:0]       grnt_reg, grnt_next;
   logic [1:0]       owner_reg, owner_next;
   logic [1:0]       last_reg, last_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             preempt_reg, preempt_next;

   logic [3:0] req;
   logic [1:0] cand_idx [4];
   logic [3:0] any_hit;
   logic [3:0] other_hit;
   logic       any_found, other_found;
   logic [1:0] any_idx, other_idx;

   assign req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

   // Candidate gi is the master at round-robin distance gi+1 from the last owner.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cand
         assign cand_idx[gi]  = last_reg + 2'(gi + 1);
         assign any_hit[gi]   = req[cand_idx[gi]];
         assign other_hit[gi] = req[cand_idx[gi]] && (cand_idx[gi] != owner_reg);
      end
   endgenerate

   always_comb begin
      any_found   = |any_hit;
      other_found = |other_hit;
      any_idx     = 2'd0;
      other_idx   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (any_hit[i])   any_idx   = cand_idx[i];
         if (other_hit[i]) other_idx = cand_idx[i];
      end
   end

   always_comb begin
      state_next   = state_reg;
      grnt_next    = grnt_reg;
      owner_next   = owner_reg;
      last_next    = last_reg;
      cnt_next     = cnt_reg;
      preempt_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (any_found) begin
               state_next = OWNED;
               grnt_next  = 4'b0001 << any_idx;
               owner_next = any_idx;
               last_next  = any_idx;
               cnt_next   = '0;
            end
         end
         OWNED: begin
            if (!req[owner_reg]) begin
               // Release wins over a coincident timeout, so preempt stays low here.
               cnt_next = '0;
               if (any_found) begin
                  grnt_next  = 4'b0001 << any_idx;
                  owner_next = any_idx;
                  last_next  = any_idx;
               end else begin
                  grnt_next  = 4'b0000;
                  state_next = IDLE;
               end
            end else if (PREEMPT_EN && (cnt_reg == HOLD_LIM) && other_found && bus.s_as_) begin
               grnt_next    = 4'b0001 << other_idx;
               owner_next   = other_idx;
               last_next    = other_idx;
               cnt_next     = '0;
               preempt_next = 1'b1;
            end else if (cnt_reg != HOLD_LIM) begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            grnt_next  = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         grnt_reg    <= 4'b0000;
         owner_reg   <= 2'd0;
         last_reg    <= 2'd3;
         cnt_reg     <= '0;
         preempt_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         grnt_reg    <= grnt_next;
         owner_reg   <= owner_next;
         last_reg    <= last_next;
         cnt_reg     <= cnt_next;
         preempt_reg <= preempt_next;
      end
   end

   assign bus.m0_grnt_ = ~grnt_reg[0];
   assign bus.m1_grnt_ = ~grnt_reg[1];
   assign bus.m2_grnt_ = ~grnt_reg[2];
   assign bus.m3_grnt_ = ~grnt_reg[3];
   assign bus.owner    = owner_reg;
   assign bus.busy     = (state_reg == OWNED);
   assign bus.preempt  = preempt_reg;
endmodule
